// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel 8-bit PWM LED driver with frame-synchronous colour capture.
// Define RGB_PWM_GAMMA_EN to map each channel through a squared-law duty curve.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_start
);
  localparam logic [15:0] P_LAST = 16'(PRESCALE - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q;
  logic [15:0] p_q, p_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  sh_r_q, sh_g_q, sh_b_q;
  logic [7:0]  duty_r, duty_g, duty_b;
  logic        led_r_q, led_g_q, led_b_q, fs_q;
  logic        tick, wrap;
`ifdef RGB_PWM_GAMMA_EN
  function automatic logic [7:0] gamma(input logic [7:0] c);
    logic [15:0] sq;
    sq = {8'd0, c} * {8'd0, c};
    return (c == 8'hFF) ? 8'hFF : sq[15:8];
  endfunction
  assign duty_r = gamma(sh_r_q);
  assign duty_g = gamma(sh_g_q);
  assign duty_b = gamma(sh_b_q);
`else
  assign duty_r = sh_r_q;
  assign duty_g = sh_g_q;
  assign duty_b = sh_b_q;
`endif
  // The counter stops at 254 so a duty of 255 stays on for the whole frame.
  assign tick  = p_q == P_LAST;
  assign wrap  = tick && cnt_q == 8'd254;
  assign p_d   = tick ? 16'd0 : p_q + 16'd1;
  assign cnt_d = wrap ? 8'd0 : cnt_q + {7'd0, tick};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      sh_r_q  <= '0;
      sh_g_q  <= '0;
      sh_b_q  <= '0;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
      fs_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      p_q     <= '0;
      cnt_q   <= '0;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
      fs_q    <= enable;
      if (enable) begin
        state_q <= RUN;
        {sh_r_q, sh_g_q, sh_b_q} <= light;
      end
    end else if (!enable) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      led_r_q <= 1'b0;
      led_g_q <= 1'b0;
      led_b_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      led_r_q <= cnt_q < duty_r;
      led_g_q <= cnt_q < duty_g;
      led_b_q <= cnt_q < duty_b;
      fs_q    <= wrap;
      if (wrap) {sh_r_q, sh_g_q, sh_b_q} <= light;
    end
  assign led_r       = led_r_q;
  assign led_g       = led_g_q;
  assign led_b       = led_b_q;
  assign frame_start = fs_q;
endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

- Drives three physical LED pins from the 24-bit RGB `light` word produced by the lights selector.
- Each 8-bit channel becomes a pulse-width-modulated output with duty proportional to its code.
- The `light` word is captured once per PWM frame into shadow registers, so a colour change never produces a partial or glitched frame.
- Sits directly downstream of the selector, between it and the board LED pins.

## Interface

**Parameters**
- `PRESCALE`, default 4: system clocks per PWM tick; legal range 1..65535.

**Ports**
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: run request; low forces LEDs dark.
- `light`, input, 24: RGB code; [23:16]=R, [15:8]=G, [7:0]=B.
- `led_r`, output, 1: red PWM pin, registered.
- `led_g`, output, 1: green PWM pin, registered.
- `led_b`, output, 1: blue PWM pin, registered.
- `frame_start`, output, 1: one-clock pulse marking the first cycle of each PWM frame.

## Operation

**State machine: IDLE, RUN**
- Reset (`rst`=0) forces, asynchronously: state IDLE, prescaler `p`=0, PWM counter `cnt`=0, shadows `sh_r/g/b`=0, and `led_r`, `led_g`, `led_b`, `frame_start` all 0.

**IDLE**
- Counters held at 0; LEDs and `frame_start` driven 0.
- Edge with `enable`=1 goes to RUN: `p`<=0, `cnt`<=0, shadows<=`light`, `frame_start`<=1.

**RUN**
- `p` counts 0..PRESCALE-1; tick = (`p`==PRESCALE-1); `p` wraps to 0 on tick.
- `cnt` (8 bits) advances on tick over 0..254 only; 254 wraps to 0.
- A frame is 255 ticks = 255*PRESCALE clocks.

**Frame boundary**
- Occurs on the edge where tick is high and `cnt`==254.
- On that edge: `cnt`<=0, shadows<=`light`, `frame_start`<=1.
- `frame_start` is 0 on every other edge.

**Per-channel output**
- Every edge, `led_x`<=(`cnt` < `duty_x`), using the current registered `cnt` and duty.
- Unsigned 8-bit compare. Duty 0 is never on; duty 255 is always on (`cnt` never reaches 255).

**Leaving RUN**
- Edge with `enable`=0 returns to IDLE. On that same edge, LEDs<=0, `frame_start`<=0, counters<=0.
- A frame in progress is abandoned, not completed.

**Simultaneous events**
- `enable` falling on a boundary edge: the IDLE transition wins; no `frame_start`.
- `light` changing mid-frame has no effect until the next boundary.

**Reset mid-frame**
- Immediate, asynchronous return to the reset values above.
- Release with `enable`=1 restarts via the IDLE→RUN entry on the first edge after release.

## Timing

- From `enable` sampled high in IDLE: `frame_start`=1 after 1 edge, and first valid LED level after 2 edges.
- LED outputs lag `cnt` by exactly one clock.
- `light` to LED latency: sampled at the next frame boundary, visible one clock later.
- Worst case is one frame + 1 clock = 255*PRESCALE+1 clocks.
- On time per frame = duty*PRESCALE clocks (linear mode).
- `frame_start` period in steady RUN = 255*PRESCALE clocks exactly.

## Configuration

**`RGB_PWM_GAMMA_EN`**
- **Defined:** duty_x = 255 when c==255, otherwise (c*c)>>8, where c is the channel shadow and the product is computed at 16 bits. Example: 128→64, 16→1, 15→0.
- The gamma map is applied combinationally to the shadow output; no added latency.
- **Undefined:** duty_x = shadow value directly (linear).
- Frame timing, reset values and the state machine are identical in both builds.

## Test plan

1. **Linear duties.** PRESCALE=1, reset, `enable`=1, `light`=24'h80FF00.
   - Per 255-clock frame: `led_r` high exactly 128 clocks, then low 127.
   - `led_g` constantly 1; `led_b` constantly 0.
   - `frame_start` every 255 clocks.
2. **Update only at boundary.** PRESCALE=4, `light`=24'h400000. Change to 24'hC00000 at clock 300 (mid-frame).
   - Current frame keeps 64*4=256 red-high clocks.
   - Next frame has 192*4=768.
3. **Enable mid-frame.** Drop `enable` at clock 100.
   - LEDs 0 and `frame_start` 0 from the next edge; `cnt`=0 held.
   - Re-assert: `frame_start` pulses 1 edge later, LEDs valid 2 edges later.
4. **Async reset mid-frame.** Assert `rst`=0 between clock edges.
   - All outputs 0 immediately, without waiting for an edge.
   - After release, with `enable`=1, the first `frame_start` comes on the first edge.
5. **Gamma build.** Build with `RGB_PWM_GAMMA_EN`, PRESCALE=1, `light`=24'h80FF0F.
   - Red high 64 clocks/frame; green always on; blue always off (15→0).
6. **Simultaneous boundary and disable.** Deassert `enable` on the exact edge where `cnt`==254 and tick is high.
   - No `frame_start` pulse; state IDLE; shadows unchanged.
